seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexes the 7-segment display that shows the game score. Sits directly
//  downstream of the BCD digit decoder: drives its digit index and score input,
//  registers its segment pattern back, and drives the shared segment bus and the
//  per-digit anodes. Score updates are frame-synchronous, so a digit change never
//  appears in the middle of a refresh frame. Dead-time between digits prevents ghosting.
// PARAMETERS
//  REFRESH_DIV   100000  clk cycles per digit slot (1 kHz/digit at 100 MHz); must be > BLANK_CYCLES
//  BLANK_CYCLES  1000    cycles at the start of each slot with all anodes off; must be >= 1
//  NUM_DIGITS    4       digits scanned, range 1..8
// PORTS
//  clk         in   1           system clock; all logic on its rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  score       in   8           new score value, sampled when score_load=1
//  score_load  in   1           one-cycle request to display score
//  score_held  out  8           frame-stable score, drives the decoder's ins input
//  digit_sel   out  3           current digit index, drives the decoder's counter input
//  seg_in      in   8           active-low segment pattern from the decoder (8'hFF = blank)
//  seg         out  8           active-low segment bus to the pins
//  an          out  NUM_DIGITS  active-low anodes, at most one bit low at any time
//  frame_done  out  1           one-cycle pulse on the last cycle of each frame
// BEHAVIOUR
//  Reset (async, immediate): seg=8'hFF, an=all 1s, digit_sel=0, score_held=0,
//   pending score=0, frame_done=0, prescaler=0, state=BLANK. Deassertion starts slot 0 at cycle 0.
//  Prescaler slot_cnt is $clog2(REFRESH_DIV) bits wide and counts 0..REFRESH_DIV-1, then wraps to 0.
//  FSM, two states:
//   BLANK: slot_cnt < BLANK_CYCLES. an=all 1s, seg=8'hFF. Goes to SHOW when slot_cnt=BLANK_CYCLES-1.
//   SHOW:  an[digit_sel]=0, all other anode bits 1. seg <= seg_in every cycle (1-cycle latency).
//          On slot_cnt=REFRESH_DIV-1, goes to BLANK and seg <= 8'hFF on the same edge.
//  digit_sel changes only on the BLANK entry edge: +1, and wraps NUM_DIGITS-1 -> 0.
//   This gives the decoder BLANK_CYCLES to settle before the digit is shown.
//  Frame boundary is the last cycle of the slot with digit_sel=NUM_DIGITS-1. On that cycle:
//   frame_done=1; on the following edge score_held <= pending and digit_sel <= 0.
//  score_load rules:
//   - score_load=1 sets pending <= score; score_held does not change until the frame boundary.
//   - Several loads within one frame: the last one wins.
//   - A load on the boundary cycle itself bypasses pending: score_held <= score at that edge.
//  seg_in=8'hFF (a blanked leading digit) is shown as-is; the anode is still driven.
//  Reset mid-frame aborts the frame with no frame_done; a pending score is discarded.
//  Two anode bits low at the same time is illegal in every state.
// STRUCTURE
//  Shared header seg7_defs.vh: SEG_BLANK=8'hFF, MAX_DIGITS=8, state encodings ST_BLANK/ST_SHOW.
//   The BCD decoder also uses SEG_BLANK from this header.
//  One sub-module: seg7_slot_timer (parameterised prescaler). Outputs slot_cnt, blank_end
//   and slot_end strobes.
//  FSM, digit index, anode decode and score shadow stay in this module.
// TESTING  (bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4; BCD model
//          connected for realism)
//  1 Reset: pull rst_n low mid-SHOW of digit 2. Outputs change immediately, without a clock edge:
//    an=4'hF, seg=8'hFF, digit_sel=0, score_held=0.
//  2 Scan order from reset: cycles 0-1 an=4'hF; cycles 2-7 an=4'b1110 and seg follows seg_in
//    one cycle later; cycle 8 digit_sel=1; cycles 10-15 an=4'b1101. frame_done=1 only at
//    cycle 31; cycle 32 is back to digit 0.
//  3 score_load with score=42 at cycle 5: score_held stays 0 through cycle 31 and is 42 from
//    cycle 32. With seg_in from the BCD model, digit 0 shows "2" in the next frame.
//  4 score_load 17 at cycle 4, then 99 at cycle 20: score_held=99 after the boundary;
//    17 never appears on score_held.
//  5 score_load with score=7 exactly on the frame_done cycle: score_held=7 on the next
//    cycle with no extra frame of delay. Then pulse rst_n mid-frame after a load of 55:
//    score_held=0 and 55 is never applied.
//  6 Assertion over 10000 random cycles with random score_load: $countones(~an)<=1 always;
//    seg==8'hFF whenever an==4'hF; digit_sel changes only while an==4'hF.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver and the BCD decoder beside it.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package seg7_scan_driver_pkg;

    // Active-low segment pattern with every segment dark.
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Widest display the digit index can address.
    localparam int         MAX_DIGITS = 8;
    localparam int         SEL_W      = $clog2(MAX_DIGITS);

    // Scan FSM: dark dead-time at slot start, then the selected digit lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Next digit index in scan order, wrapping after the last digit.
    function automatic logic [SEL_W-1:0] next_digit(input logic [SEL_W-1:0] cur,
                                                    input logic [SEL_W-1:0] last);
        return (cur == last) ? '0 : cur + SEL_W'(1);
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 and strobes the dead-time end and slot end.
// Latency: strobes are combinational decodes of the registered count (same cycle).
// Backpressure: none; free-running from reset release.
module seg7_slot_timer #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = $clog2(REFRESH_DIV)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_slot_cnt,
    output logic             o_blank_end,
    output logic             o_slot_end
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_slot_end;

    assign w_slot_end  = (r_cnt == SLOT_LAST);
    assign o_slot_end  = w_slot_end;
    assign o_blank_end = (r_cnt == BLANK_LAST);
    assign o_slot_cnt  = r_cnt;

    // Slot counter: wraps to zero after the last cycle of each slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan with per-slot dead-time and frame-synchronous score update.
// Latency: seg follows seg_in by 1 cycle while lit; score reaches score_held at the next frame end.
// Backpressure: none; score_load is a fire-and-forget pulse, last load in a frame wins.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int NUM_DIGITS   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_score,
    input  logic                  i_score_load,
    output logic [7:0]            o_score_held,
    output logic [2:0]            o_digit_sel,
    input  logic [7:0]            i_seg_in,
    output logic [7:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic                  o_frame_done
);

    localparam int               CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      w_slot_cnt;
    logic                  w_blank_end;
    logic                  w_slot_end;
    logic                  w_frame_end;

    scan_state_t           r_state;
    scan_state_t           w_state_nxt;
    logic [7:0]            r_seg;
    logic [7:0]            w_seg_nxt;
    logic [SEL_W-1:0]      r_digit_sel;
    logic [7:0]            r_pending;
    logic [7:0]            r_score_held;
    logic [NUM_DIGITS-1:0] w_an;

    seg7_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_slot_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .o_slot_cnt   (w_slot_cnt),
        .o_blank_end  (w_blank_end),
        .o_slot_end   (w_slot_end)
    );

    // The last cycle of the last digit's slot closes the frame.
    assign w_frame_end  = w_slot_end && (r_digit_sel == LAST_DIGIT);

    assign o_frame_done = w_frame_end;
    assign o_seg        = r_seg;
    assign o_an         = w_an;
    assign o_digit_sel  = r_digit_sel;
    assign o_score_held = r_score_held;

    // Scan state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next segment bus value; the bus is forced dark on the slot-end edge.
    always_comb begin
        w_state_nxt = r_state;
        w_seg_nxt   = SEG_BLANK;
        case (r_state)
            ST_BLANK: begin
                if (w_blank_end) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_slot_end) begin
                    w_state_nxt = ST_BLANK;
                end else begin
                    w_seg_nxt   = i_seg_in;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
            end
        endcase
    end

    // Segment bus register: one cycle behind the decoder while lit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg <= SEG_BLANK;
        end else begin
            r_seg <= w_seg_nxt;
        end
    end

    // Digit index steps only as the dead-time begins, giving the decoder time to settle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digit_sel <= '0;
        end else if (w_slot_end) begin
            r_digit_sel <= next_digit(r_digit_sel, LAST_DIGIT);
        end
    end

    // Score shadow: loads collect in pending; a load on the frame-end cycle goes straight through.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending    <= '0;
            r_score_held <= '0;
        end else begin
            if (i_score_load) begin
                r_pending <= i_score;
            end
            if (w_frame_end) begin
                r_score_held <= i_score_load ? i_score : r_pending;
            end
        end
    end

    // Anode decode: only the selected digit is pulled low, and only while lit.
    always_comb begin
        w_an = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((r_state == ST_SHOW) && (r_digit_sel == SEL_W'(i))) begin
                w_an[i] = 1'b0;
            end
        end
    end

    // The FSM must stay aligned with the prescaler's dead-time window.
    a_blank_window: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_state == ST_BLANK) == (w_slot_cnt <= BLANK_LAST));

    // Never two digits lit at once.
    a_one_anode: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $countones(~o_an) <= 1);

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int ND    = 4;
    localparam int FRAME = SLOT * ND;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] score = 8'd0;
    logic       score_load = 1'b0;
    logic [7:0] score_held;
    logic [2:0] digit_sel;
    logic [7:0] seg_in;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame_done;

    logic       bcd_mode = 1'b1;
    logic [7:0] rnd_seg = 8'hFF;
    logic       chk_en = 1'b0;
    int         cur = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .REFRESH_DIV  (SLOT),
        .BLANK_CYCLES (BLANK),
        .NUM_DIGITS   (ND)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_score      (score),
        .i_score_load (score_load),
        .o_score_held (score_held),
        .o_digit_sel  (digit_sel),
        .i_seg_in     (seg_in),
        .o_seg        (seg),
        .o_an         (an),
        .o_frame_done (frame_done)
    );

    // BCD decoder model: active-low gfedcba, leading zeros blanked.
    function automatic logic [7:0] bcd_seg(input logic [7:0] val, input logic [2:0] dig);
        int v;
        int p;
        int d;
        logic [7:0] r;
        v = int'(val);
        p = 1;
        for (int i = 0; i < int'(dig); i++) p = p * 10;
        if (dig != 3'd0 && v < p) return 8'hFF;
        d = (v / p) % 10;
        case (d)
            0: r = 8'hC0;
            1: r = 8'hF9;
            2: r = 8'hA4;
            3: r = 8'hB0;
            4: r = 8'h99;
            5: r = 8'h92;
            6: r = 8'h82;
            7: r = 8'hF8;
            8: r = 8'h80;
            default: r = 8'h90;
        endcase
        return r;
    endfunction

    assign seg_in = bcd_mode ? bcd_seg(score_held, digit_sel) : rnd_seg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance to cycle k (cycles counted from reset release), landing 1 time unit after the edge.
    task automatic go(input int k);
        if (k > cur) begin
            repeat (k - cur) @(posedge clk);
            #1;
            cur = k;
        end
    endtask

    // Reference model: cycle count since reset plus the score rules.
    int         m_cyc;
    logic [7:0] m_held;
    logic [7:0] m_pend;
    logic [7:0] m_prev_seg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc      <= 0;
            m_held     <= 8'd0;
            m_pend     <= 8'd0;
            m_prev_seg <= 8'hFF;
        end else begin
            m_prev_seg <= seg_in;
            if (score_load) m_pend <= score;
            if (m_cyc % FRAME == FRAME - 1) m_held <= score_load ? score : m_pend;
            m_cyc <= m_cyc + 1;
        end
    end

    // Per-cycle compare against the model plus the display invariants.
    logic [2:0] prev_dsel;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        int         p;
        int         d;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        if (rst_n && chk_en) begin
            p = m_cyc % SLOT;
            d = (m_cyc / SLOT) % ND;
            exp_an = 4'hF;
            if (p >= BLANK) exp_an[d] = 1'b0;
            exp_seg = (p >= BLANK + 1) ? m_prev_seg : 8'hFF;
            chk("model_an", an, exp_an);
            chk("model_seg", seg, exp_seg);
            chk("model_digit_sel", digit_sel, d);
            chk("model_frame_done", frame_done, (m_cyc % FRAME == FRAME - 1));
            chk("model_score_held", score_held, m_held);
            chk("inv_one_anode", ($countones(~an) <= 1), 1);
            if (an == 4'hF) chk("inv_seg_dark", seg, 8'hFF);
            if (prev_valid && digit_sel != prev_dsel) chk("inv_dsel_change_dark", an, 4'hF);
            prev_dsel  <= digit_sel;
            prev_valid <= 1'b1;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cur = 0;
        chk_en = 1'b1;

        // Reset state and scan order
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_digit_sel", digit_sel, 0);
        chk("rst_score_held", score_held, 0);
        chk("rst_frame_done", frame_done, 0);
        go(2);  chk("c2_an", an, 4'b1110);
        go(3);  chk("c3_seg_zero", seg, 8'hC0);
        go(5);  score = 8'd42; score_load = 1'b1;
        go(6);  score_load = 1'b0;
        go(7);  chk("c7_an", an, 4'b1110);
        go(8);  chk("c8_digit_sel", digit_sel, 1); chk("c8_an", an, 4'hF);
        go(10); chk("c10_an", an, 4'b1101);
        go(11); chk("c11_seg_blank_lead", seg, 8'hFF); chk("c11_an", an, 4'b1101);
        go(30); chk("c30_frame_done", frame_done, 0);
        go(31); chk("c31_frame_done", frame_done, 1); chk("c31_digit_sel", digit_sel, 3);
                chk("c31_held", score_held, 0);
        go(32); chk("c32_digit_sel", digit_sel, 0); chk("c32_held", score_held, 42);
                chk("c32_frame_done", frame_done, 0);
        go(35); chk("c35_seg_two", seg, 8'hA4);
        go(43); chk("c43_seg_four", seg, 8'h99);

        // Two loads in one frame: last wins
        go(68); score = 8'd17; score_load = 1'b1;
        go(69); score_load = 1'b0;
        go(84); score = 8'd99; score_load = 1'b1;
        go(85); score_load = 1'b0;
        go(95); chk("c95_held", score_held, 42);
        go(96); chk("c96_held", score_held, 99);
        go(99); chk("c99_seg_nine", seg, 8'h90);

        // Load on the frame-end cycle bypasses pending
        go(127); chk("c127_frame_done", frame_done, 1); score = 8'd7; score_load = 1'b1;
        go(128); score_load = 1'b0; chk("c128_held", score_held, 7);

        // Reset mid-show of digit 2 discards a pending load
        go(130); score = 8'd55; score_load = 1'b1;
        go(131); score_load = 1'b0;
        go(148); chk("c148_digit_sel", digit_sel, 2); chk("c148_an", an, 4'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 8'hFF);
        chk("arst_digit_sel", digit_sel, 0);
        chk("arst_held", score_held, 0);
        chk("arst_frame_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cur = 0;
        go(31); chk("post_rst_c31_held", score_held, 0);
        go(32); chk("post_rst_c32_held", score_held, 0);

        // Random loads and random decoder patterns
        bcd_mode = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            go(cur + 1);
            score_load = ($urandom_range(7) == 0);
            score      = 8'($urandom);
            rnd_seg    = 8'($urandom);
        end
        score_load = 1'b0;
        go(cur + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
